// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
//   Shared definitions for the I2C write arbiter.
//   - state_t          : frame sequencer states
//   - RW_WRITE         : R/W bit value appended to the 7-bit address
//   - QUARTERS_PER_BIT : SCL quarter-periods per bit slot
// ---------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK_A,
    ST_DATA,
    ST_ACK_D,
    ST_STOP,
    ST_DONE
  } state_t;

  localparam logic RW_WRITE         = 1'b0;
  localparam int   QUARTERS_PER_BIT = 4;

endpackage

// File: rtl/i2c_rr_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_rr_arbiter
//   Round-robin selector. Combinationally picks the first active request at
//   or after the pointer; the pointer moves to (finished index + 1) when the
//   owning frame completes.
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset (pointer -> 0)
//   i_req        in   N_REQ request levels
//   i_advance    in   1 = frame of i_done_idx finished this cycle
//   i_done_idx   in   index of the requester whose frame finished
//   o_grant      out  one-hot selection (all zero when no request)
//   o_idx        out  binary index of the selection
//   o_valid      out  1 = some request is active
// ---------------------------------------------------------------------------
module i2c_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_advance,
  input  logic [IDX_W-1:0] i_done_idx,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_next;
  logic [IDX_W-1:0] w_cand;

  // Walk the requesters starting at the pointer, wrapping at N_REQ-1;
  // the first active one wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = r_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
      w_cand = (w_cand == IDX_LAST) ? '0 : w_cand + 1'b1;
    end
  end

  assign w_ptr_next = (i_done_idx == IDX_LAST) ? '0 : i_done_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= w_ptr_next;
    end
  end

endmodule

// File: rtl/i2c_write_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_write_arbiter
//   Shares one open-drain I2C bus between N_REQ requesters. A round-robin
//   winner gets one single-byte write frame:
//   START, addr[6:0]+W, ACK, data[7:0], ACK, STOP.
//   Each bit slot is 4 quarters of CLK_DIV clk each.
// Ports
//   clk         in   system clock
//   rst         in   synchronous active-high reset (releases bus at once)
//   i_req       in   [N_REQ]   request levels
//   i_req_addr  in   [7*N_REQ] slave address, requester i at [7i+6:7i]
//   i_req_data  in   [8*N_REQ] write byte, requester i at [8i+7:8i]
//   o_grant     out  [N_REQ]   one-hot owner of the current frame
//   o_done      out  [N_REQ]   one-clk end-of-frame pulse to the owner
//   o_nack      out  valid with o_done: address or data not acknowledged
//   o_busy      out  frame in progress
//   o_scl       out  SCL level (1 = released)
//   o_sda_oe    out  1 = pull SDA low
//   i_sda       in   sampled SDA line
// ---------------------------------------------------------------------------
module i2c_write_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [7*N_REQ-1:0] i_req_addr,
  input  logic [8*N_REQ-1:0] i_req_data,
  output logic [N_REQ-1:0]   o_grant,
  output logic [N_REQ-1:0]   o_done,
  output logic               o_nack,
  output logic               o_busy,
  output logic               o_scl,
  output logic               o_sda_oe,
  input  logic               i_sda
);

  localparam int               IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int               QCNT_W    = $clog2(CLK_DIV);
  localparam logic [QCNT_W-1:0] QCNT_LAST = QCNT_W'(CLK_DIV - 1);
  localparam logic [1:0]       Q_LAST    = 2'(QUARTERS_PER_BIT - 1);
  localparam logic [1:0]       Q_SAMPLE  = 2'd2;

  // Per-requester views of the packed address/data buses.
  logic [6:0] w_addr_arr [N_REQ];
  logic [7:0] w_data_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_addr_arr[gi] = i_req_addr[7*gi +: 7];
    assign w_data_arr[gi] = i_req_data[8*gi +: 8];
  end

  // State
  state_t           r_state,  r_state_next;
  logic [QCNT_W-1:0] r_qcnt;
  logic [1:0]       r_q,      r_q_next;
  logic [2:0]       r_bitcnt, r_bitcnt_next;
  logic [7:0]       r_shift,  r_shift_next;
  logic [7:0]       r_data,   r_data_next;
  logic [N_REQ-1:0] r_grant,  r_grant_next;
  logic [IDX_W-1:0] r_gidx,   r_gidx_next;
  logic             r_nack,   r_nack_next;
  logic             r_scl,    r_scl_next;
  logic             r_sda_oe, r_sda_oe_next;

  logic             w_tick;
  logic [N_REQ-1:0] w_arb_grant;
  logic [IDX_W-1:0] w_arb_idx;
  logic             w_arb_valid;
  logic             w_in_done;

  assign w_in_done = (r_state == ST_DONE);

  i2c_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_advance  (w_in_done),
    .i_done_idx (r_gidx),
    .o_grant    (w_arb_grant),
    .o_idx      (w_arb_idx),
    .o_valid    (w_arb_valid)
  );

  // Quarter-period prescaler: held at zero outside a frame so every frame
  // starts with a full first quarter.
  assign w_tick = (r_qcnt == QCNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_qcnt <= '0;
    end else if (r_state == ST_IDLE || r_state == ST_DONE || w_tick) begin
      r_qcnt <= '0;
    end else begin
      r_qcnt <= r_qcnt + 1'b1;
    end
  end

  // Next-state logic. On each tick the sequencer advances one quarter, then
  // the bus levels for the quarter being entered are derived from the new
  // state/quarter, so bus pins only ever move on tick edges.
  always_comb begin
    r_state_next  = r_state;
    r_q_next      = r_q;
    r_bitcnt_next = r_bitcnt;
    r_shift_next  = r_shift;
    r_data_next   = r_data;
    r_grant_next  = r_grant;
    r_gidx_next   = r_gidx;
    r_nack_next   = r_nack;
    r_scl_next    = r_scl;
    r_sda_oe_next = r_sda_oe;

    case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) begin
          r_state_next  = ST_START;
          r_grant_next  = w_arb_grant;
          r_gidx_next   = w_arb_idx;
          r_shift_next  = {w_addr_arr[w_arb_idx], RW_WRITE};
          r_data_next   = w_data_arr[w_arb_idx];
          r_nack_next   = 1'b0;
          r_q_next      = 2'd0;
          r_bitcnt_next = 3'd7;
        end
      end

      ST_DONE: begin
        r_state_next = ST_IDLE;
        r_grant_next = '0;
        r_q_next     = 2'd0;
      end

      default: begin
        if (w_tick) begin
          r_q_next = r_q + 2'd1;

          // ACK slot: slave holds SDA low to acknowledge.
          if ((r_state == ST_ACK_A || r_state == ST_ACK_D) && r_q == Q_SAMPLE) begin
            r_nack_next = i_sda;
          end

          if (r_q == Q_LAST) begin
            case (r_state)
              ST_START: r_state_next = ST_ADDR;
              ST_ADDR: begin
                if (r_bitcnt == 3'd0) begin
                  r_state_next = ST_ACK_A;
                end else begin
                  r_bitcnt_next = r_bitcnt - 3'd1;
                  r_shift_next  = {r_shift[6:0], 1'b0};
                end
              end
              ST_ACK_A: begin
                // Address NACK skips the data byte entirely.
                if (r_nack) begin
                  r_state_next = ST_STOP;
                end else begin
                  r_state_next  = ST_DATA;
                  r_shift_next  = r_data;
                  r_bitcnt_next = 3'd7;
                end
              end
              ST_DATA: begin
                if (r_bitcnt == 3'd0) begin
                  r_state_next = ST_ACK_D;
                end else begin
                  r_bitcnt_next = r_bitcnt - 3'd1;
                  r_shift_next  = {r_shift[6:0], 1'b0};
                end
              end
              ST_ACK_D: r_state_next = ST_STOP;
              ST_STOP:  r_state_next = ST_DONE;
              default:  r_state_next = r_state;
            endcase
          end

          // Bus levels for the quarter now being entered.
          case (r_state_next)
            ST_START: begin
              // Q0 idle, Q1-Q2 SDA low under high SCL, Q3 SCL low.
              r_scl_next    = (r_q_next != 2'd3);
              r_sda_oe_next = (r_q_next != 2'd0);
            end
            ST_ADDR, ST_DATA: begin
              r_scl_next = (r_q_next == 2'd1) || (r_q_next == 2'd2);
              if (r_q_next == 2'd0) begin
                r_sda_oe_next = ~r_shift_next[7];
              end
            end
            ST_ACK_A, ST_ACK_D: begin
              r_scl_next    = (r_q_next == 2'd1) || (r_q_next == 2'd2);
              r_sda_oe_next = 1'b0;
            end
            ST_STOP: begin
              // Q0 SDA low with SCL low, Q1 SCL rises, Q3 SDA released.
              r_scl_next    = (r_q_next != 2'd0);
              r_sda_oe_next = (r_q_next != 2'd3);
            end
            default: begin
              r_scl_next    = 1'b1;
              r_sda_oe_next = 1'b0;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_q      <= 2'd0;
      r_bitcnt <= 3'd0;
      r_shift  <= 8'd0;
      r_data   <= 8'd0;
      r_grant  <= '0;
      r_gidx   <= '0;
      r_nack   <= 1'b0;
      r_scl    <= 1'b1;
      r_sda_oe <= 1'b0;
    end else begin
      r_state  <= r_state_next;
      r_q      <= r_q_next;
      r_bitcnt <= r_bitcnt_next;
      r_shift  <= r_shift_next;
      r_data   <= r_data_next;
      r_grant  <= r_grant_next;
      r_gidx   <= r_gidx_next;
      r_nack   <= r_nack_next;
      r_scl    <= r_scl_next;
      r_sda_oe <= r_sda_oe_next;
    end
  end

  assign o_grant  = r_grant;
  assign o_done   = w_in_done ? r_grant : '0;
  assign o_nack   = w_in_done & r_nack;
  assign o_busy   = (r_state != ST_IDLE);
  assign o_scl    = r_scl;
  assign o_sda_oe = r_sda_oe;

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_write_arbiter
//   Directed bench: a byte-decoding I2C slave at address 7'h2A sits on the
//   wired-AND bus; each step checks grant/done/nack timing and the bytes the
//   slave decoded against hand-computed values.
// ---------------------------------------------------------------------------
module tb_i2c_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [13:0] req_addr = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  grant, done;
  logic        nack, busy, scl, sda_oe;
  logic        sda;

  // Slave model state
  logic        slave_drive = 1'b0;
  logic        nack_data   = 1'b0;
  logic        active      = 1'b0;
  logic        addr_ok     = 1'b0;
  logic        prev_scl    = 1'b1;
  logic        prev_sda    = 1'b1;
  logic [7:0]  sh          = '0;
  logic [7:0]  rx_addr     = '0;
  logic [7:0]  rx_data     = '0;
  int          pos         = 0;
  int          byte_idx    = 0;
  int          stops       = 0;
  int          rx_data_cnt = 0;

  // Done monitor
  int dc0 = 0, dc1 = 0, multi = 0;

  int n_checks = 0;
  int n_err    = 0;

  logic [1:0] cap_done;
  logic       cap_nack;
  int         cyc, base0, base1, sbase, rbase;

  always #5 clk = ~clk;

  assign sda = ~(sda_oe | slave_drive);

  i2c_write_arbiter #(.N_REQ(2), .CLK_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (req),
    .i_req_addr (req_addr),
    .i_req_data (req_data),
    .o_grant    (grant),
    .o_done     (done),
    .o_nack     (nack),
    .o_busy     (busy),
    .o_scl      (scl),
    .o_sda_oe   (sda_oe),
    .i_sda      (sda)
  );

  // I2C slave: START/STOP detection, bit capture on SCL rise, ACK drive from
  // the falling edge after the 8th bit until the falling edge after the 9th.
  always @(scl or sda) begin
    if (prev_scl === 1'b1 && scl === 1'b1 && prev_sda === 1'b1 && sda === 1'b0) begin
      active   = 1'b1;
      pos      = 0;
      byte_idx = 0;
    end else if (prev_scl === 1'b1 && scl === 1'b1 && prev_sda === 1'b0 && sda === 1'b1) begin
      if (active) stops++;
      active = 1'b0;
    end else if (prev_scl === 1'b0 && scl === 1'b1 && active) begin
      if (pos < 8) begin
        sh = {sh[6:0], sda};
        pos++;
      end else begin
        pos = 0;
        byte_idx++;
      end
    end else if (prev_scl === 1'b1 && scl === 1'b0 && active) begin
      if (pos == 8) begin
        if (byte_idx == 0) begin
          rx_addr     = sh;
          addr_ok     = (sh == 8'h54);
          slave_drive = addr_ok;
        end else if (byte_idx == 1) begin
          rx_data     = sh;
          rx_data_cnt++;
          slave_drive = addr_ok && !nack_data;
        end else begin
          slave_drive = 1'b0;
        end
      end else begin
        slave_drive = 1'b0;
      end
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  always @(posedge clk) begin
    if (done[0]) dc0++;
    if (done[1]) dc1++;
    if (done[0] && done[1]) multi++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, output int c);
    logic seen;
    seen = 1'b0;
    c = 0;
    while (c < 1000 && !seen) begin
      tick();
      c++;
      if (done !== 2'b00) begin
        seen     = 1'b1;
        cap_done = done;
        cap_nack = nack;
      end
    end
    if (!seen) begin
      cap_done = 2'bxx;
      cap_nack = 1'bx;
    end
    check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    // ---------------- reset ----------------
    tick(); tick();
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_done",  {30'd0, done},  32'd0);
    check("rst_nack",  {31'd0, nack},  32'd0);
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_scl",   {31'd0, scl},   32'd1);
    check("rst_sdaoe", {31'd0, sda_oe},32'd0);
    rst = 1'b0;
    tick(); tick();

    // ---------------- 1: write 2A <- A5 ----------------
    sbase    = stops;
    req_addr = {7'h2A, 7'h2A};
    req_data = {8'h3C, 8'hA5};
    req      = 2'b01;
    tick();
    check("t1_grant", {30'd0, grant}, 32'h1);
    check("t1_busy",  {31'd0, busy},  32'd1);
    req = 2'b00;
    wait_done("t1", cyc);
    check("t1_cycles",  cyc + 1, 32'd321);
    check("t1_done",    {30'd0, cap_done}, 32'h1);
    check("t1_nack",    {31'd0, cap_nack}, 32'd0);
    check("t1_rx_addr", {24'd0, rx_addr}, 32'h54);
    check("t1_rx_data", {24'd0, rx_data}, 32'hA5);
    tick();
    check("t1_grant_clr", {30'd0, grant}, 32'd0);
    check("t1_busy_clr",  {31'd0, busy},  32'd0);
    check("t1_scl_idle",  {31'd0, scl},   32'd1);
    check("t1_oe_idle",   {31'd0, sda_oe},32'd0);
    check("t1_stop",      stops - sbase,  32'd1);

    // ---------------- 2: absent address 11 ----------------
    rbase    = rx_data_cnt;
    req_addr = {7'h2A, 7'h11};
    req      = 2'b01;
    tick();
    req = 2'b00;
    wait_done("t2", cyc);
    check("t2_cycles",  cyc + 1, 32'd177);
    check("t2_done",    {30'd0, cap_done}, 32'h1);
    check("t2_nack",    {31'd0, cap_nack}, 32'd1);
    check("t2_rx_addr", {24'd0, rx_addr},  32'h22);
    check("t2_no_data", rx_data_cnt - rbase, 32'd0);
    tick();

    // ---------------- 3: both requesting, alternation ----------------
    // Pointer is 1 after two done[0] frames, so requester 1 goes first.
    base0    = dc0;
    base1    = dc1;
    req_addr = {7'h2A, 7'h2A};
    req_data = {8'h3C, 8'hA5};
    req      = 2'b11;
    tick();
    check("t3_grant1", {30'd0, grant}, 32'h2);
    wait_done("t3a", cyc);
    check("t3a_cycles", cyc + 1, 32'd321);
    check("t3a_done",   {30'd0, cap_done}, 32'h2);
    check("t3a_data",   {24'd0, rx_data},  32'h3C);
    wait_done("t3b", cyc);
    check("t3b_cycles", cyc, 32'd322);
    check("t3b_done",   {30'd0, cap_done}, 32'h1);
    check("t3b_data",   {24'd0, rx_data},  32'hA5);
    wait_done("t3c", cyc);
    check("t3c_done",   {30'd0, cap_done}, 32'h2);
    wait_done("t3d", cyc);
    check("t3d_done",   {30'd0, cap_done}, 32'h1);
    req = 2'b00;
    tick(); tick();
    check("t3_dc0",   dc0 - base0, 32'd2);
    check("t3_dc1",   dc1 - base1, 32'd2);
    check("t3_multi", multi, 32'd0);
    check("t3_idle",  {31'd0, busy}, 32'd0);

    // ---------------- 4: data NACK ----------------
    nack_data = 1'b1;
    req_data  = {8'h3C, 8'h5A};
    req       = 2'b01;
    tick();
    req = 2'b00;
    wait_done("t4", cyc);
    check("t4_cycles", cyc + 1, 32'd321);
    check("t4_done",   {30'd0, cap_done}, 32'h1);
    check("t4_nack",   {31'd0, cap_nack}, 32'd1);
    check("t4_data",   {24'd0, rx_data},  32'h5A);
    nack_data = 1'b0;
    tick(); tick();

    // ---------------- 5: reset during data bit 3 ----------------
    req_data = {8'hC3, 8'h5A};
    req      = 2'b10;
    tick();
    req = 2'b00;
    repeat (229) tick();
    check("t5_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    check("t5_scl",   {31'd0, scl},    32'd1);
    check("t5_oe",    {31'd0, sda_oe}, 32'd0);
    check("t5_grant", {30'd0, grant},  32'd0);
    check("t5_busy",  {31'd0, busy},   32'd0);
    rst = 1'b0;
    tick(); tick();
    req = 2'b10;
    tick();
    check("t5_regrant", {30'd0, grant}, 32'h2);
    req = 2'b00;
    repeat (3) tick();
    check("t5_start_q0_oe", {31'd0, sda_oe}, 32'd0);
    tick();
    check("t5_start_oe",  {31'd0, sda_oe}, 32'd1);
    check("t5_start_scl", {31'd0, scl},    32'd1);
    wait_done("t5", cyc);
    check("t5_cycles", cyc + 5, 32'd321);
    check("t5_done",   {30'd0, cap_done}, 32'h2);
    check("t5_data",   {24'd0, rx_data},  32'hC3);
    tick(); tick();

    // ---------------- 6: req[1] drops mid-frame ----------------
    req_data = {8'h81, 8'h5A};
    req      = 2'b10;
    tick();
    repeat (100) tick();
    req = 2'b00;
    base1 = dc1;
    wait_done("t6", cyc);
    check("t6_cycles", cyc + 101, 32'd321);
    check("t6_done",   {30'd0, cap_done}, 32'h2);
    check("t6_nack",   {31'd0, cap_nack}, 32'd0);
    check("t6_data",   {24'd0, rx_data},  32'h81);
    repeat (40) tick();
    check("t6_once",  dc1 - base1, 32'd1);
    check("t6_busy",  {31'd0, busy},   32'd0);
    check("t6_scl",   {31'd0, scl},    32'd1);
    check("t6_oe",    {31'd0, sda_oe}, 32'd0);
    check("t6_grant", {30'd0, grant},  32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
